// File: rtl/conv_pool_if.sv
// Handshake bundle between a frame source and the conv/pool engine.
interface conv_pool_if #(
   parameter int DW = 16
);
   logic                 in_valid;
   logic signed [DW-1:0] in_data;
   logic [1:0]           opt;
   logic                 out_valid;
   logic signed [DW-1:0] out_data;
   logic                 busy;

   modport master (output in_valid, in_data, opt, input out_valid, out_data, busy);
   modport slave  (input in_valid, in_data, opt, output out_valid, out_data, busy);
endinterface

// File: rtl/conv_pool_engine.sv
// Streams an IMG x IMG image and a 3x3 kernel, computes the valid convolution
// with optional ReLU and saturation, then emits a 2x2 max/average pooled map.
module conv_pool_engine #(
   parameter int DW  = 16,
   parameter int IMG = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   conv_pool_if.slave bus
);
   localparam int C    = IMG - 2;
   localparam int P    = C / 2;
   localparam int AW   = 2 * DW + 4;
   localparam int NI   = IMG * IMG;
   localparam int NW   = NI + 9;
   localparam int CNTW = $clog2(NW);
   localparam int RW   = $clog2(IMG);
   localparam int CRW  = $clog2(C);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_CALC = 2'd2;
   localparam logic [1:0] S_OUT  = 2'd3;

   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   logic [1:0]           state_q, state_d;
   logic [CNTW-1:0]      cnt_q, cnt_d;
   logic [RW-1:0]        row_q, row_d, col_q, col_d;
   logic [1:0]           opt_q, opt_d;
   logic                 out_valid_q, out_valid_d;
   logic signed [DW-1:0] out_data_q, out_data_d;

   logic signed [DW-1:0] img_mem  [IMG][IMG];
   logic signed [DW-1:0] ker_mem  [9];
   logic signed [DW-1:0] conv_mem [C][C];

   logic                 img_we, ker_we, conv_we;
   logic [3:0]           k_addr;
   logic signed [AW-1:0] acc;
   logic signed [DW-1:0] conv_val, pool_max, pool_avg;

   assign k_addr = 4'(cnt_q - CNTW'(NI));

   always_comb begin
      logic signed [DW-1:0]   pa, pb;
      logic signed [2*DW-1:0] prod;
      acc = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            pa   = img_mem[row_q + RW'(i)][col_q + RW'(j)];
            pb   = ker_mem[4'(i * 3 + j)];
            prod = (2*DW)'(pa) * (2*DW)'(pb);
            acc  = acc + AW'(prod);
         end
      end
      if (opt_q[0] && acc[AW-1]) conv_val = '0;
      else if (acc > SAT_MAX)    conv_val = SAT_MAX[DW-1:0];
      else if (acc < SAT_MIN)    conv_val = SAT_MIN[DW-1:0];
      else                       conv_val = acc[DW-1:0];
   end

   always_comb begin
      logic [CRW-1:0]       r0, r1, c0, c1;
      logic signed [DW-1:0] a, b, c, d, m0, m1;
      logic signed [DW+1:0] psum, pshift;
      r0 = CRW'({row_q, 1'b0});
      c0 = CRW'({col_q, 1'b0});
      r1 = r0 | CRW'(1);
      c1 = c0 | CRW'(1);
      a  = conv_mem[r0][c0];
      b  = conv_mem[r0][c1];
      c  = conv_mem[r1][c0];
      d  = conv_mem[r1][c1];
      m0 = (a > b) ? a : b;
      m1 = (c > d) ? c : d;
      pool_max = (m0 > m1) ? m0 : m1;
      psum     = (DW+2)'(a) + (DW+2)'(b) + (DW+2)'(c) + (DW+2)'(d);
      pshift   = psum >>> 2;
      pool_avg = pshift[DW-1:0];
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      row_d       = row_q;
      col_d       = col_q;
      opt_d       = opt_q;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      img_we      = 1'b0;
      ker_we      = 1'b0;
      conv_we     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               state_d = S_READ;
               opt_d   = bus.opt;
               img_we  = 1'b1;
               cnt_d   = CNTW'(1);
               col_d   = RW'(1);
            end
         end
         S_READ: begin
            if (!bus.in_valid) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               row_d   = '0;
               col_d   = '0;
            end else begin
               if (cnt_q < CNTW'(NI)) begin
                  img_we = 1'b1;
                  if (col_q == RW'(IMG - 1)) begin
                     col_d = '0;
                     row_d = row_q + RW'(1);
                  end else begin
                     col_d = col_q + RW'(1);
                  end
               end else begin
                  ker_we = 1'b1;
               end
               if (cnt_q == CNTW'(NW - 1)) begin
                  state_d = S_CALC;
                  cnt_d   = '0;
                  row_d   = '0;
                  col_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end
         end
         S_CALC: begin
            conv_we = 1'b1;
            if (col_q == RW'(C - 1)) begin
               col_d = '0;
               if (row_q == RW'(C - 1)) begin
                  state_d = S_OUT;
                  row_d   = '0;
               end else begin
                  row_d = row_q + RW'(1);
               end
            end else begin
               col_d = col_q + RW'(1);
            end
         end
         S_OUT: begin
            out_valid_d = 1'b1;
            out_data_d  = opt_q[1] ? pool_avg : pool_max;
            if (col_q == RW'(P - 1)) begin
               col_d = '0;
               if (row_q == RW'(P - 1)) begin
                  state_d = S_IDLE;
                  row_d   = '0;
               end else begin
                  row_d = row_q + RW'(1);
               end
            end else begin
               col_d = col_q + RW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         row_q       <= '0;
         col_q       <= '0;
         opt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         row_q       <= row_d;
         col_q       <= col_d;
         opt_q       <= opt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // NOTE: storage arrays carry no reset; every frame rewrites them before they are read.
   always_ff @(posedge clk) begin
      if (img_we)  img_mem[row_q][col_q]              <= bus.in_data;
      if (ker_we)  ker_mem[k_addr]                    <= bus.in_data;
      if (conv_we) conv_mem[CRW'(row_q)][CRW'(col_q)] <= conv_val;
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.busy      = (state_q != S_IDLE) | out_valid_q;
endmodule
